// File: rtl/bcd_display_ctrl.sv
// Binary-to-BCD double-dabble converter driving four 7-seg digit buses; results WIDTH+2 cycles after LOAD.
// LOAD is ignored while converting, except in the DONE cycle; define BCD_LZB_EN for leading-zero blanking.
module bcd_display_ctrl #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  output logic             busy,
  output logic             done,
  output logic             ovf,
  output logic [3:0]       num0,
  output logic [3:0]       num1,
  output logic [3:0]       num2,
  output logic [3:0]       num3
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, CONV, FINISH} state_t;

  state_t           state;
  logic [WIDTH-1:0] sr;
  logic [19:0]      scratch;
  logic [19:0]      adj;
  logic [CW-1:0]    cnt;
  logic [15:0]      disp;

  // Per-digit add-3 correction applied before each shift.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 5; i++) begin
      if (scratch[4*i +: 4] >= 4'd5)
        adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
    end
  end

  // Digits above the most significant nonzero one blank to F; units never blank.
  always_comb begin
    disp = scratch[15:0];
`ifdef BCD_LZB_EN
    if (scratch[15:12] == 4'd0) begin
      disp[15:12] = 4'hF;
      if (scratch[11:8] == 4'd0) begin
        disp[11:8] = 4'hF;
        if (scratch[7:4] == 4'd0)
          disp[7:4] = 4'hF;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      sr      <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      ovf     <= 1'b0;
      num0    <= 4'hF;
      num1    <= 4'hF;
      num2    <= 4'hF;
      num3    <= 4'hF;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (load) begin
            sr      <= value;
            scratch <= '0;
            cnt     <= CW'(WIDTH);
            busy    <= 1'b1;
            state   <= CONV;
          end else begin
            busy <= 1'b0;
          end
        end
        CONV: begin
          busy           <= 1'b1;
          {scratch, sr}  <= {adj, sr} << 1;
          cnt            <= cnt - CW'(1);
          if (cnt == CW'(1))
            state <= FINISH;
        end
        FINISH: begin
          // busy stays high through the DONE cycle and drops one edge later.
          busy  <= 1'b1;
          done  <= 1'b1;
          state <= IDLE;
          if (scratch[19:16] != 4'd0) begin
            ovf  <= 1'b1;
            num0 <= 4'hF;
            num1 <= 4'hF;
            num2 <= 4'hF;
            num3 <= 4'hF;
          end else begin
            ovf  <= 1'b0;
            num0 <= disp[3:0];
            num1 <= disp[7:4];
            num2 <= disp[11:8];
            num3 <= disp[15:12];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Bench for bcd_display_ctrl: timeline/arithmetic reference model plus directed literal checks.
module tb_bcd_display_ctrl;

  localparam int W = 14;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] value = '0;
  logic         busy, done, ovf;
  logic [3:0]   num0, num1, num2, num3;

  int nvec = 0;
  int nerr = 0;

  bcd_display_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .value(value),
    .busy(busy), .done(done), .ovf(ovf),
    .num0(num0), .num1(num1), .num2(num2), .num3(num3)
  );

  always #5 clk = ~clk;

  // Expected display from plain decimal arithmetic.
  function automatic logic [15:0] expect_nums(int v);
    logic [3:0] d3, d2, d1, d0;
    if (v > 9999) return 16'hFFFF;
    d3 = 4'(v / 1000);
    d2 = 4'((v / 100) % 10);
    d1 = 4'((v / 10) % 10);
    d0 = 4'(v % 10);
`ifdef BCD_LZB_EN
    if (v < 1000) d3 = 4'hF;
    if (v < 100)  d2 = 4'hF;
    if (v < 10)   d1 = 4'hF;
`endif
    return {d3, d2, d1, d0};
  endfunction

  // Reference model: phase counts cycles since an accepted LOAD (0 = idle).
  int          phase;
  int          mv;
  logic [15:0] m_nums;
  logic        m_ovf;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase  <= 0;
      mv     <= 0;
      m_nums <= 16'hFFFF;
      m_ovf  <= 1'b0;
    end else begin
      if ((phase == 0 || phase == W + 2) && load) begin
        phase <= 1;
        mv    <= int'(value);
      end else if (phase == 0 || phase == W + 2) begin
        phase <= 0;
      end else begin
        phase <= phase + 1;
      end
      if (phase == W + 1) begin
        m_nums <= expect_nums(mv);
        m_ovf  <= (mv > 9999);
      end
    end
  end

  logic [18:0] exp_vec, got_vec;
  always @(negedge clk) begin
    exp_vec = {phase != 0, phase == W + 2, m_ovf, m_nums};
    got_vec = {busy, done, ovf, num3, num2, num1, num0};
    nvec++;
    if (got_vec !== exp_vec) begin
      nerr++;
      $display("FAIL model t=%0t busy/done/ovf/nums got %b/%b/%b/%h want %b/%b/%b/%h",
               $time, got_vec[18], got_vec[17], got_vec[16], got_vec[15:0],
               exp_vec[18], exp_vec[17], exp_vec[16], exp_vec[15:0]);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    nvec++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive LOAD for one edge; returns just after edge 1.
  task automatic do_load(input int v);
    load  = 1'b1;
    value = W'(v);
    tick(1);
    load  = 1'b0;
  endtask

  task automatic conv(input string name, input int v, input logic [15:0] want, input logic want_ovf);
    do_load(v);
    chk({name, "_busy1"}, 32'(busy), 32'd1);
    tick(W + 1);
    chk({name, "_nums"}, {num3, num2, num1, num0}, 32'(want));
    chk({name, "_ovf"}, 32'(ovf), 32'(want_ovf));
    chk({name, "_done"}, 32'(done), 32'd1);
    tick(1);
    chk({name, "_end"}, {busy, done}, 32'd0);
  endtask

  logic [15:0] e42, e0, e5, e56;

  initial begin
`ifdef BCD_LZB_EN
    e42 = 16'hFF42; e0 = 16'hFFF0; e5 = 16'hFFF5; e56 = 16'hFF56;
`else
    e42 = 16'h0042; e0 = 16'h0000; e5 = 16'h0005; e56 = 16'h0056;
`endif
    tick(2);
    chk("reset", {busy, done, ovf, num3, num2, num1, num0}, 32'h0FFFF);
    rst_n = 1'b1;
    tick(5);
    chk("idle", {busy, done, ovf, num3, num2, num1, num0}, 32'h0FFFF);

    do_load(1234);
    chk("1234_busy_e1", 32'(busy), 32'd1);
    tick(W);
    chk("1234_e15_nodone", 32'(done), 32'd0);
    tick(1);
    chk("1234_e16", {done, ovf, num3, num2, num1, num0}, 32'h21234);
    tick(1);
    chk("1234_e17", {busy, done}, 32'd0);

    conv("9999", 9999, 16'h9999, 1'b0);
    conv("10000", 10000, 16'hFFFF, 1'b1);
    conv("16383", 16383, 16'hFFFF, 1'b1);
    conv("42", 42, e42, 1'b0);
    conv("0", 0, e0, 1'b0);

    // LOAD mid-conversion is dropped; LOAD in the DONE cycle is taken.
    do_load(5);
    tick(3);
    load = 1'b1; value = W'(7);
    tick(1);
    load = 1'b0;
    tick(W + 2 - 5);
    chk("ign_nums", {num3, num2, num1, num0}, 32'(e5));
    chk("ign_done", 32'(done), 32'd1);
    conv("b2b", 1234, 16'h1234, 1'b0);

    // Asynchronous abort mid-conversion.
    do_load(1234);
    tick(7);
    rst_n = 1'b0;
    #1;
    chk("abort", {busy, done, ovf, num3, num2, num1, num0}, 32'h0FFFF);
    tick(2);
    rst_n = 1'b1;
    tick(1);
    conv("56", 56, e56, 1'b0);

    tick(3);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
